// File: rtl/multi_blinker_pkg.sv
// Shared definitions for the multi-channel blinker: mode field width and mode encodings.
package multi_blinker_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_STROBE = 2'd3
    } blinkMode_e;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: phase counter, registered mode copy and registered output.
// The channel only advances its phase on prescaler ticks shared from the top.
module blink_channel
    import multi_blinker_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_i,
    input  logic              enable_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [CW-1:0]     period_i,
    output logic              out_o
);

    blinkMode_e    modeReg_q, modeReg_d;
    blinkMode_e    modeNow;
    logic [CW-1:0] phaseCnt_q, phaseCnt_d;
    logic          out_q, out_d;
    logic [CW-1:0] lastPhase;
    logic          wrapHit;

    // Next-state logic: gating first, then mode-change clear, then per-mode behaviour.
    always_comb begin
        modeNow    = blinkMode_e'(mode_i);
        modeReg_d  = modeNow;
        phaseCnt_d = phaseCnt_q;
        out_d      = out_q;
        lastPhase  = (period_i == '0) ? '0 : (period_i - CW'(1));
        wrapHit    = (phaseCnt_q >= lastPhase);

        if (!enable_i) begin
            phaseCnt_d = '0;
            out_d      = 1'b0;
        end else if (modeNow != modeReg_q) begin
            phaseCnt_d = '0;
            out_d      = 1'b0;
        end else begin
            case (modeNow)
                MODE_OFF: begin
                    phaseCnt_d = '0;
                    out_d      = 1'b0;
                end
                MODE_ON: begin
                    phaseCnt_d = '0;
                    out_d      = 1'b1;
                end
                MODE_BLINK: begin
                    if (tick_i) begin
                        if (wrapHit) begin
                            phaseCnt_d = '0;
                            out_d      = ~out_q;
                        end else begin
                            phaseCnt_d = phaseCnt_q + CW'(1);
                        end
                    end
                end
                MODE_STROBE: begin
                    out_d = 1'b0;
                    if (tick_i) begin
                        if (wrapHit) begin
                            phaseCnt_d = '0;
                            out_d      = 1'b1;
                        end else begin
                            phaseCnt_d = phaseCnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    phaseCnt_d = '0;
                    out_d      = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset back to OFF and zero phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            modeReg_q  <= MODE_OFF;
            phaseCnt_q <= '0;
            out_q      <= 1'b0;
        end else begin
            modeReg_q  <= modeReg_d;
            phaseCnt_q <= phaseCnt_d;
            out_q      <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/multi_blinker.sv
// N independent blink channels sharing one free-running prescaler tick.
module multi_blinker
    import multi_blinker_pkg::*;
#(
    parameter int N   = 4,
    parameter int DIV = 8,
    parameter int CW  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        switch,
    input  logic [MODE_W*N-1:0] mode,
    input  logic [CW*N-1:0]     period,
    output logic [N-1:0]        out
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] prescaleCnt_q, prescaleCnt_d;
    logic          tick;

    // Prescaler wraps at DIV-1; with DIV=1 it sits at zero and tick stays high.
    always_comb begin
        tick          = (prescaleCnt_q == LAST);
        prescaleCnt_d = tick ? '0 : (prescaleCnt_q + PW'(1));
    end

    // Prescaler register, cleared by reset so every channel restarts in phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaleCnt_q <= '0;
        end else begin
            prescaleCnt_q <= prescaleCnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : gChannel
        blink_channel #(
            .CW(CW)
        ) uChannel (
            .clock    (clock),
            .reset    (reset),
            .tick_i   (tick),
            .enable_i (switch[i]),
            .mode_i   (mode[MODE_W*i +: MODE_W]),
            .period_i (period[CW*i +: CW]),
            .out_o    (out[i])
        );
    end

endmodule

// File: doc/multi_blinker.md
MULTI_BLINKER -- requirements
Module: multi_blinker

Interface
REQ-001 Parameter N, default 4: number of independent blink channels (>=1).
REQ-002 Parameter DIV, default 8: clock cycles per prescaler tick (>=1).
REQ-003 Parameter CW, default 4: width of each channel's period field.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 switch  input  N  per-channel enable; bit i gates channel i.
REQ-007 mode  input  2*N  per-channel mode, bits [2i+1:2i] for channel i.
REQ-008 period  input  CW*N  per-channel period in ticks, bits [CW*(i+1)-1:CW*i].
REQ-009 out  output  N  registered per-channel output.

Function
REQ-010 The prescaler SHALL count 0..DIV-1 and wrap, free-running. It SHALL assert internal tick for one cycle when count==DIV-1; with DIV=1 tick SHALL be constant high.
REQ-011 Effective period SHALL be P = max(period[i],1); a period of 0 SHALL behave as 1.
REQ-012 Each channel SHALL hold a CW-bit phase counter pcnt and a registered out[i].
REQ-013 Mode 0 OFF: out[i] SHALL be 0 and pcnt SHALL be 0.
REQ-014 Mode 1 ON: out[i] SHALL be 1 from the cycle after entry, and pcnt SHALL be 0.
REQ-015 Mode 2 BLINK: on each tick, if pcnt>=P-1 then pcnt SHALL become 0 and out[i] SHALL toggle; otherwise pcnt SHALL increment. Between ticks out[i] and pcnt SHALL hold.
REQ-016 Mode 3 STROBE: out[i] SHALL be 1 for exactly one cycle following a tick with pcnt>=P-1; pcnt SHALL wrap as in BLINK; out[i] SHALL be 0 otherwise.
REQ-017 The >= compare SHALL ensure a period reduced mid-count wraps at the next tick, never after 2^CW ticks.
REQ-018 switch[i]=0 SHALL force out[i]=0 and pcnt=0 at the next edge, regardless of mode.
REQ-019 On a switch[i] 0->1 transition in BLINK, out[i] SHALL stay 0 until the first wrap, then go 1.
REQ-020 A mode[i] change, detected against a registered copy, SHALL clear pcnt and out[i] at the next edge. The new mode SHALL then apply from that point.
REQ-021 Channels SHALL be fully independent and share only the prescaler tick.
REQ-022 Output latency SHALL be one clock from the qualifying tick or condition; out SHALL never depend combinationally on inputs.

Reset
REQ-023 While reset=1, the prescaler SHALL be 0, all pcnt SHALL be 0, all out SHALL be 0, and the registered modes SHALL be 0 (OFF) at the next edge.
REQ-024 Reset SHALL have priority over switch, mode and tick.
REQ-025 Reset asserted mid-operation SHALL abandon all phases; after release every channel SHALL restart from pcnt=0 and prescaler=0.

Structure
REQ-026 Mode encodings (OFF/ON/BLINK/STROBE) and the 2-bit mode width SHALL live in a shared package.
REQ-027 Per-channel logic SHALL be one sub-module, blink_channel, instantiated N times by a generate loop. The prescaler SHALL stay in multi_blinker.

Verification (N=4, DIV=2, CW=4)
REQ-028 Reset: hold reset high 2 cycles with arbitrary inputs -> out=4'b0000 at the next edge, and prescaler=0.
REQ-029 BLINK: ch0 with period=3 and switch[0]=1 from reset release -> out[0] rises 6 cycles after release, then toggles every 6 cycles.
REQ-030 STROBE: ch1 with period=2 -> out[1] is a single-cycle pulse every 4 cycles. Period=0 on ch2 in BLINK -> out[2] toggles every 2 cycles.
REQ-031 Gating: drop switch[0] mid-half-period -> out[0]=0 next cycle. Re-raise it -> out[0] stays low a full 6 cycles, then rises.
REQ-032 Mode change and reset: switch ch3 from ON to BLINK -> out[3] goes 0 next cycle, then follows REQ-019. Assert reset mid-run -> all outputs 0, and the phase restarts as in REQ-029.
